// File: rtl/stream_upsize_fifo_if.sv
// Handshake bundle for the narrow-to-wide stream upsizer: narrow input stream
// on the s_* side, wide lane-array output stream on the m_* side.
interface stream_upsize_fifo_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4
);
    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;

    logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] m_keep_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    // The upsizer itself.
    modport slave (
        input  s_data_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    // The environment: producer and consumer sides together.
    modport master (
        output s_data_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_upsize_fifo.sv
// Packs T_DATA_RATIO narrow beats into one wide word (flushing early on last)
// and buffers finished words in a small FIFO ahead of the wide consumer.
module stream_upsize_fifo #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    stream_upsize_fifo_if.slave bus
);

    localparam int CNT_W = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_DATA_RATIO - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]        cnt;
    logic [T_DATA_WIDTH-1:0] lanes [T_DATA_RATIO];

    logic [T_DATA_WIDTH-1:0] push_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] push_keep;

    logic [T_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH][T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] mem_keep [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_last;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic accept;
    logic word_done;
    logic push;
    logic pop;
    logic is_full;
    logic out_valid;

    // Ready is a function of registered occupancy only, so full stalls the
    // producer even when the consumer pops in the same cycle.
    assign is_full       = (occ == OCC_FULL);
    assign bus.s_ready_o = rst_n && !is_full;

    assign accept    = bus.s_valid_i && bus.s_ready_o;
    assign word_done = (cnt == CNT_LAST) || bus.s_last_i;
    assign push      = accept && word_done;

    assign out_valid = (occ != '0);
    assign pop       = out_valid && bus.m_ready_i;

    // ---- assembly stage: merge stored lanes with the completing beat
    always_comb begin
        push_keep = '0;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            push_data[i] = '0;
            if (CNT_W'(i) < cnt) begin
                push_data[i] = lanes[i];
            end else if (CNT_W'(i) == cnt) begin
                push_data[i] = bus.s_data_i;
            end
            push_keep[i] = (CNT_W'(i) <= cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                lanes[i] <= '0;
            end
        end else if (accept) begin
            if (word_done) begin
                cnt <= '0;
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    lanes[i] <= '0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    if (CNT_W'(i) == cnt) begin
                        lanes[i] <= bus.s_data_i;
                    end
                end
            end
        end
    end

    // ---- buffer stage: pointer and occupancy control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Entry storage needs no reset: it is only observed through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                mem_data[wr_ptr][i] <= push_data[i];
            end
            mem_keep[wr_ptr] <= push_keep;
            mem_last[wr_ptr] <= bus.s_last_i;
        end
    end

    // ---- output stage: head entry, zeroed whenever nothing is buffered
    always_comb begin
        bus.m_valid_o = out_valid;
        bus.m_keep_o  = '0;
        bus.m_last_o  = 1'b0;
        for (int i = 0; i < T_DATA_RATIO; i++) begin
            bus.m_data_o[i] = '0;
        end
        if (out_valid) begin
            bus.m_keep_o = mem_keep[rd_ptr];
            bus.m_last_o = mem_last[rd_ptr];
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                bus.m_data_o[i] = mem_data[rd_ptr][i];
            end
        end
    end

endmodule

// File: tb/tb_stream_upsize_fifo.sv
// Directed bench for stream_upsize_fifo at W=8, R=4, D=2: hand-computed words
// are queued up front and matched against every word the consumer pops.
module tb_stream_upsize_fifo;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic clk;
    logic rst_n;

    stream_upsize_fifo_if #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) bus ();

    stream_upsize_fifo #(
        .T_DATA_WIDTH(8),
        .T_DATA_RATIO(4),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int    n_checks;
    int    n_errors;
    int    word_cnt;
    int    stall_cnt;
    int    cyc_cnt;
    word_t exp_q [$];
    word_t exp_w;
    logic [31:0] mon_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] head_data();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = bus.m_data_o[i];
        return d;
    endfunction

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Present one beat and hold it until accepted; stalls and cycles are tallied.
    task automatic send_beat(input logic [7:0] d, input logic l);
        bit acc;
        int waited;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        bus.s_last_i  = l;
        acc    = 1'b0;
        waited = 0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = bus.s_ready_o;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        stall_cnt += waited;
        cyc_cnt   += waited + 1;
        if (!acc) chk("beat accept timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Consumer-side scoreboard: a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
            word_cnt++;
            mon_data = head_data();
            if (exp_q.size() == 0) begin
                chk("unexpected word", mon_data, 32'hDEAD_BEEF);
            end else begin
                exp_w = exp_q.pop_front();
                chk("word data", mon_data, exp_w.data);
                chk("word keep", {28'd0, bus.m_keep_o}, {28'd0, exp_w.keep});
                chk("word last", {31'd0, bus.m_last_o}, {31'd0, exp_w.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        n_checks  = 0;
        n_errors  = 0;
        word_cnt  = 0;
        stall_cnt = 0;
        cyc_cnt   = 0;
        rst_n         = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst m_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("rst m_data", head_data(), 32'd0);
        chk("rst m_keep", {28'd0, bus.m_keep_o}, 32'd0);
        chk("rst m_last", {31'd0, bus.m_last_o}, 32'd0);
        chk("rst s_ready low", {31'd0, bus.s_ready_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-rst s_ready", {31'd0, bus.s_ready_o}, 32'd1);

        // Full word with one-cycle output latency
        bus.m_ready_i = 1'b1;
        expect_word(32'h4433_2211, 4'b1111, 1'b1);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        chk("t1 no early valid", {31'd0, bus.m_valid_o}, 32'd0);
        send_beat(8'h44, 1'b1);
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        chk("t1 valid after 4th", {31'd0, bus.m_valid_o}, 32'd1);
        idle(1);
        chk("t1 valid one cycle", {31'd0, bus.m_valid_o}, 32'd0);

        // Partial flush then a multi-word packet starting back in lane 0
        expect_word(32'h0000_A2A1, 4'b0011, 1'b1);
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b1);
        expect_word(32'h0403_0201, 4'b1111, 1'b0);
        expect_word(32'h0000_0605, 4'b0011, 1'b1);
        for (int i = 1; i <= 6; i++) send_beat(8'(i), i == 6);
        idle(3);
        chk("t3 drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: two words fill the buffer, ninth beat waits
        bus.m_ready_i = 1'b0;
        expect_word(32'h0302_0100, 4'b1111, 1'b0);
        expect_word(32'h0706_0504, 4'b1111, 1'b0);
        expect_word(32'h0B0A_0908, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) send_beat(8'(i), 1'b0);
        chk("t4 s_ready after 8th", {31'd0, bus.s_ready_o}, 32'd0);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'h08;
        bus.s_last_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t4 s_ready held low", {31'd0, bus.s_ready_o}, 32'd0);
            chk("t4 head stable", head_data(), 32'h0302_0100);
            chk("t4 keep stable", {28'd0, bus.m_keep_o}, 32'hF);
        end
        bus.m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t4 s_ready after pop", {31'd0, bus.s_ready_o}, 32'd1);
        for (int i = 8; i < 12; i++) send_beat(8'(i), i == 11);
        idle(4);
        chk("t4 drained", 32'(exp_q.size()), 32'd0);

        // Sustained full rate with a draining consumer
        for (int w = 0; w < 10; w++) begin
            expect_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'b1111, w == 9);
        end
        base      = word_cnt;
        stall_cnt = 0;
        cyc_cnt   = 0;
        for (int i = 0; i < 40; i++) send_beat(8'(i), i == 39);
        idle(3);
        chk("t5 stalls", 32'(stall_cnt), 32'd0);
        chk("t5 cycles", 32'(cyc_cnt), 32'd40);
        chk("t5 words", 32'(word_cnt - base), 32'd10);
        chk("t5 drained", 32'(exp_q.size()), 32'd0);

        // Reset with one word buffered and three beats assembled
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) send_beat(8'(8'h10 + i), 1'b0);
        chk("t6 word buffered", {31'd0, bus.m_valid_o}, 32'd1);
        bus.s_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6 m_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("t6 m_data", head_data(), 32'd0);
        chk("t6 m_keep", {28'd0, bus.m_keep_o}, 32'd0);
        chk("t6 m_last", {31'd0, bus.m_last_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t6 s_ready", {31'd0, bus.s_ready_o}, 32'd1);
        bus.m_ready_i = 1'b1;
        expect_word(32'h0000_0055, 4'b0001, 1'b1);
        send_beat(8'h55, 1'b1);
        bus.s_valid_i = 1'b0;
        chk("t6 valid after flush", {31'd0, bus.m_valid_o}, 32'd1);
        idle(3);
        chk("t6 drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
